// File: rtl/alu_issue_buf.sv
// rtl/alu_issue_buf.sv - ID-to-EX issue stage: funct decode, B-operand select, 2-entry skid FIFO feeding yAlu
module alu_issue_buf #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [31:0]      in_imm,
    input  logic             in_use_imm,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic [2:0]       out_op,
    output logic             out_illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        illegal;
    } entry_t;

    entry_t     mem [2];
    entry_t     mem_n [2];
    entry_t     head, head_n, in_entry;
    logic [1:0] count, count_n;
    logic       wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic       push, pop;

    always_comb begin
        in_entry         = '0;
        in_entry.a       = in_rs1;
        in_entry.b       = in_use_imm ? in_imm : in_rs2;
        in_entry.op      = OP_ADD;
        in_entry.illegal = 1'b0;
        case (in_funct3)
            3'b000:  in_entry.op = (!in_use_imm && in_funct7b5) ? OP_SUB : OP_ADD;
            3'b111:  in_entry.op = OP_AND;
            3'b110:  in_entry.op = OP_OR;
            3'b010:  in_entry.op = OP_SLT;
            default: in_entry.illegal = 1'b1;
        endcase
    end

    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head is registered from the post-edge FIFO state so it holds its last value once empty.
    always_comb begin
        mem_n[0] = mem[0];
        mem_n[1] = mem[1];
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        head_n   = head;
        if (push) begin
            mem_n[wr_ptr] = in_entry;
            wr_ptr_n      = ~wr_ptr;
        end
        if (pop) begin
            rd_ptr_n = ~rd_ptr;
        end
        case ({push, pop})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase
        if (count_n != 2'd0) begin
            head_n = mem_n[rd_ptr_n];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]     <= '0;
            mem[1]     <= '0;
            head       <= '0;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            in_ready   <= 1'b1;
            issued_cnt <= '0;
        end else begin
            mem[0]   <= mem_n[0];
            mem[1]   <= mem_n[1];
            head     <= head_n;
            count    <= count_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            in_ready <= (count_n < 2'(DEPTH));
            if (pop && (issued_cnt != {CNT_W{1'b1}})) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
        end
    end

    assign out_a       = head.a;
    assign out_b       = head.b;
    assign out_op      = head.op;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_alu_issue_buf.sv
// tb/tb_alu_issue_buf.sv - self-checking bench for alu_issue_buf
module tb_alu_issue_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_rs1, in_rs2, in_imm;
    logic        in_use_imm;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_op;
    logic        out_illegal;
    logic [15:0] issued_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_issue_buf #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_illegal(out_illegal),
        .issued_cnt(issued_cnt)
    );

    typedef struct {
        logic [31:0] rs1, rs2, imm;
        logic        use_imm;
        logic [2:0]  f3;
        logic        f7b5;
        logic [31:0] ea, eb;
        logic [2:0]  eop;
        logic        eill;
    } vec_t;

    typedef struct {
        logic [31:0] a, b;
        logic [2:0]  op;
        logic        ill;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t model(input logic [31:0] rs1, rs2, imm, input logic use_imm,
                                   input logic [2:0] f3, input logic f7b5);
        exp_t e;
        e.a = rs1;
        e.b = use_imm ? imm : rs2;
        e.ill = 1'b0;
        if (f3 == 3'd0)      e.op = (f7b5 && !use_imm) ? 3'b110 : 3'b010;
        else if (f3 == 3'd7) e.op = 3'b000;
        else if (f3 == 3'd6) e.op = 3'b001;
        else if (f3 == 3'd2) e.op = 3'b111;
        else begin e.op = 3'b010; e.ill = 1'b1; end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] rs1, rs2, imm, input logic ui,
                         input logic [2:0] f3, input logic f7);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_use_imm = ui; in_funct3 = f3; in_funct7b5 = f7;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vecs[9];
    exp_t q[$];
    exp_t last, e;
    int   mcnt;
    logic push, pop;

    initial begin
        rst_n = 1'b1; out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // 1. reset then idle
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_issued", issued_cnt, 0);

        // decode/operand-select vectors, one per push, consumed immediately
        vecs[0] = '{32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 1'b1, 32'd5, 32'd7, 3'b110, 1'b0};
        vecs[1] = '{-32'sd3, 32'd9, 32'd2, 1'b1, 3'd2, 1'b0, -32'sd3, 32'd2, 3'b111, 1'b0};
        vecs[2] = '{-32'sd3, 32'd9, 32'd2, 1'b1, 3'd0, 1'b1, -32'sd3, 32'd2, 3'b010, 1'b0};
        vecs[3] = '{32'd11, 32'd4, 32'd8, 1'b0, 3'd0, 1'b0, 32'd11, 32'd4, 3'b010, 1'b0};
        vecs[4] = '{32'h1, 32'h2, 32'h3, 1'b0, 3'd1, 1'b0, 32'h1, 32'h2, 3'b010, 1'b1};
        vecs[5] = '{32'hF0, 32'h0F, 32'h3, 1'b0, 3'd7, 1'b1, 32'hF0, 32'h0F, 3'b000, 1'b0};
        vecs[6] = '{32'hA, 32'h5, 32'h77, 1'b1, 3'd6, 1'b0, 32'hA, 32'h77, 3'b001, 1'b0};
        vecs[7] = '{32'h6, 32'h7, 32'h8, 1'b1, 3'd5, 1'b1, 32'h6, 32'h8, 3'b010, 1'b1};
        vecs[8] = '{32'h9, 32'hB, 32'hC, 1'b0, 3'd4, 1'b0, 32'h9, 32'hB, 3'b010, 1'b1};
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(1, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].use_imm, vecs[i].f3, vecs[i].f7b5);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_a", i), out_a, vecs[i].ea);
            chk($sformatf("vec%0d_b", i), out_b, vecs[i].eb);
            chk($sformatf("vec%0d_op", i), out_op, vecs[i].eop);
            chk($sformatf("vec%0d_ill", i), out_illegal, vecs[i].eill);
            if (i == 0) chk("vec0_z", out_a - out_b, -32'sd2);
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), out_valid, 0);
            chk($sformatf("vec%0d_issued", i), issued_cnt, 16'(i + 1));
        end

        // 3. backpressure with two buffered entries
        do_reset();
        out_ready = 1'b0;
        drive(1, 1, 2, 0, 0, 3'd7, 0);
        @(negedge clk);
        drive(1, 3, 4, 0, 0, 3'd6, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_full_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold_op", out_op, 3'b000);
            chk("bp_hold_a", out_a, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("bp_first_op", out_op, 3'b000);
        @(negedge clk);
        chk("bp_ready_after_pop", in_ready, 1);
        chk("bp_second_op", out_op, 3'b001);
        chk("bp_second_a", out_a, 3);
        @(negedge clk);
        chk("bp_empty", out_valid, 0);
        chk("bp_hold_last", out_op, 3'b001);
        chk("bp_issued", issued_cnt, 2);

        // 6. asynchronous reset with FIFO full
        out_ready = 1'b0;
        drive(1, 8, 8, 0, 0, 3'd0, 0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("mr_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid_drop", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_issued", issued_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mr_no_stale", out_valid, 0);
        end
        chk("mr_issued_after", issued_cnt, 0);

        // randomized traffic against a queue model
        do_reset();
        last = '{0, 0, 0, 0};
        mcnt = 0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            chk("rnd_valid", out_valid, q.size() > 0);
            chk("rnd_in_ready", in_ready, q.size() < 2);
            chk("rnd_issued", issued_cnt, 16'(mcnt));
            e = (q.size() > 0) ? q[0] : last;
            chk("rnd_a", out_a, e.a);
            chk("rnd_b", out_b, e.b);
            chk("rnd_op", out_op, e.op);
            chk("rnd_ill", out_illegal, e.ill);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                  $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            push = in_valid && (q.size() < 2);
            pop  = out_ready && (q.size() > 0);
            e = model(in_rs1, in_rs2, in_imm, in_use_imm, in_funct3, in_funct7b5);
            @(negedge clk);
            if (pop) begin
                last = q.pop_front();
                mcnt++;
            end
            if (push) q.push_back(e);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_issue_buf.md
Name: alu_issue_buf

Overview:
- Upstream neighbour of the 32-bit ALU (yAlu): the ID-to-EX issue stage.
- Each cycle it accepts one decoded instruction's operands and funct fields, and selects the B operand (register or immediate).
- It translates funct3/funct7 into the ALU's 3-bit op code and buffers the result in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Output feeds yAlu a, b, op directly; an issued-op counter supports bench/perf checks.

Parameters:
- DEPTH, 2, FIFO entries; fixed at 2, other values unsupported.
- CNT_W, 16, width of the saturating issued-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an instruction
- in_ready  output  1  stage can accept this cycle
- in_rs1  input  32  operand A (register value)
- in_rs2  input  32  operand B register value
- in_imm  input  32  sign-extended immediate
- in_use_imm  input  1  1: B = in_imm; 0: B = in_rs2
- in_funct3  input  3  instruction funct3
- in_funct7b5  input  1  funct7 bit 5 (sub select)
- out_valid  output  1  head entry valid
- out_ready  input  1  ALU stage consumes head
- out_a  output  32  to yAlu a
- out_b  output  32  to yAlu b
- out_op  output  3  to yAlu op
- out_illegal  output  1  funct3 not supported by ALU
- issued_cnt  output  CNT_W  count of completed output handshakes, saturating

Behaviour:
- Reset (async, rst_n=0):
  - count=0, wr/rd pointers=0, all entry storage=0.
  - Outputs: out_valid=0, in_ready=1, out_a=out_b=0, out_op=3'b000, out_illegal=0, issued_cnt=0.
  - Reset mid-transfer discards all buffered entries; no partial state survives.
- Handshakes:
  - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
  - in_ready is a registered output, equal to (count<2) after each edge.
  - No combinational path from out_ready to in_ready.
- Decode, combinational on input, stored with the entry:
  - funct3 000, (in_use_imm==1 or funct7b5==0): op=010 (add).
  - funct3 000, in_use_imm==0 and funct7b5==1: op=110 (sub).
  - funct3 111: op=000 (and).
  - funct3 110: op=001 (or).
  - funct3 010: op=111 (slt).
  - All other funct3: op=010, illegal=1. The entry is still buffered and issued; the consumer decides on the trap.
- Operand select: B = in_use_imm ? in_imm : in_rs2. A = in_rs1. No arithmetic in this stage.
- Latency: an entry pushed at edge N appears with out_valid=1 after edge N (1 cycle). There is no bypass from input to output in the same cycle.
- FIFO states by count:
  - EMPTY (0): out_valid=0. out_* hold the last head contents (deterministic, don't-care to consumer).
  - ONE (1): out_valid=1.
  - FULL (2): out_valid=1, in_ready=0.
- Transitions:
  - push only: +1.
  - pop only: -1.
  - push&&pop in ONE: stays ONE; new entry becomes head after the old one leaves.
  - Push in FULL is impossible (in_ready=0). Pop in FULL → ONE, and in_ready=1 next cycle.
- Stability: while out_valid&&!out_ready, out_a/out_b/out_op/out_illegal stay constant.
- Pointers: 1-bit each, wrap 1→0.
- issued_cnt: +1 per pop; it holds at 2^CNT_W-1 (no wrap).

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, released → in_ready=1, out_valid=0, out_op=000, issued_cnt=0.
2. Push rs1=5, rs2=7, funct3=000, funct7b5=1, use_imm=0 with out_ready=1 → next cycle out_a=5, out_b=7, out_op=110; yAlu z=-2. Pop completes and issued_cnt=1.
3. Backpressure: out_ready=0, push an and-type entry (funct3=111) then an or-type entry (funct3=110) → in_ready=0 after the second push. out_op holds 000 for 3 idle cycles. Raise out_ready → ops 000 then 001 emerge in order; in_ready=1 one cycle after the first pop.
4. Immediate/slt: rs1=-3, imm=2, use_imm=1, funct3=010 → out_b=2, out_op=111; yAlu z=1. Same rs1=-3 with funct3=000, funct7b5=1, use_imm=1 → op=010 (add, not sub).
5. Illegal: funct3=001 → out_illegal=1, out_op=010, entry still issued.
6. Mid-operation reset with count=2: assert rst_n=0 asynchronously between edges → out_valid drops immediately and in_ready=1; after release no stale entry emerges and issued_cnt=0.
